car_traffic_controller: RTL and testbench
=========================================

# car_traffic_controller

Generates the four car positions consumed by the sprite display stage, directly upstream of it. Once per video frame, at the start of vertical blanking, it advances each car horizontally in its lane by a level-dependent step, with wrap-around at the screen edges. Positions are double-buffered, so the display never sees a partially updated set within a visible frame.

## Interface

Parameters:
- TILE_SIZE, 32, sprite edge in pixels; the reset-position spacing is defined in multiples of it.
- H_VISIBLE_AREA, 640, visible width in pixels; the wrap modulus for X.
- V_VISIBLE_AREA, 480, first blanking line; the frame-tick trigger.

Ports:
- i_Clk, input, 1, system pixel clock; the only clock.
- i_Reset, input, 1, asynchronous, active-high reset.
- i_H_Counter, input, 10, horizontal counter from the sync generator.
- i_V_Counter, input, 10, vertical counter from the sync generator.
- i_Level, input, 3, speed level 0..7; sampled on the frame tick.
- i_Freeze, input, 1, when high, the frame update commits unchanged positions.
- o_Car_1X_Position … o_Car_4X_Position, output, 10 each, car left-edge X.
- o_Car_1Y_Position … o_Car_4Y_Position, output, 9 each, car top-edge Y (lane constant).
- o_Update_Done, output, 1, one-cycle pulse when new positions become visible.

## Operation

- Frame tick:
  - Register r_V_Prev holds i_V_Counter from the previous cycle.
  - The tick is true when i_V_Counter == V_VISIBLE_AREA and r_V_Prev != V_VISIBLE_AREA, so there is exactly one tick per frame.
- FSM states and transitions:
  - S_IDLE → S_CALC (index 0) on tick; i_Level and i_Freeze are latched.
  - S_CALC: processes one car per cycle, index 0..3, writing working registers. After index 3 the FSM goes to S_COMMIT.
  - S_COMMIT: copies all working X values to the outputs, pulses o_Update_Done, then returns to S_IDLE.
- Direction: cars 1 and 3 move right (+X); cars 2 and 4 move left (−X).
- Step:
  - step = BASE_STEP[n] + latched level, where BASE_STEP = {1, 2, 1, 3}.
  - The range is 1..10 and is computed at 4-bit width.
  - With freeze latched, step = 0.
- Wrap rules, all at 11-bit intermediate width:
  - Rightward: X' = X + step; if X' >= H_VISIBLE_AREA, then X' = X' − H_VISIBLE_AREA.
  - Leftward: if X < step, then X' = X + H_VISIBLE_AREA − step; otherwise X' = X − step.
  - Result is always in 0..639.
- Y outputs are constant lane values: 96, 160, 224, 288.
- A tick arriving while not in S_IDLE is ignored. This cannot occur with legal counters and is not queued.
- i_Level changing mid-update has no effect until the next tick.

## Timing

- Reset values, applied asynchronously while i_Reset is high:
  - X outputs and working registers: 0, 5·TILE_SIZE (160), 10·TILE_SIZE (320), 15·TILE_SIZE (480).
  - Y outputs: lane constants as listed above.
  - o_Update_Done = 0; FSM = S_IDLE; r_V_Prev = 0.
- Latency: with the tick detected at edge E0, the calc edges are E1..E4. Outputs change at E5, and o_Update_Done is high for the E5→E6 cycle. Outputs are therefore stable for the whole visible frame.
- Reset mid-update abandons the working registers: outputs take reset values and no o_Update_Done is issued.
- Reset deasserted during the tick line: r_V_Prev = 0 means a tick fires if the counter already reads V_VISIBLE_AREA. This is accepted behaviour.
- Outputs are registered only; no combinational path runs from inputs to outputs.

## Structure

- Shared include frogger_constants.vh holds:
  - LANE_Y[4], BASE_STEP[4], INIT_X[4], CAR_DIR[4];
  - FSM state encodings (S_IDLE=2'd0, S_CALC=2'd1, S_COMMIT=2'd2).
- One combinational sub-module, Car_Lane_Step:
  - Inputs: X, step, direction.
  - Output: wrapped X'.
  - One instance is shared across the four serialised calc cycles, muxed by index.
- Top level contains the tick detector, FSM, working register file, output register file and latches.

## Test plan

- Reset, then 1 frame with level 0 → X = {1, 158, 321, 477}; one o_Update_Done pulse, exactly 5 edges after the tick edge.
- Car 1 at 638, level 1 (step 2) → wraps to 0; at 639, step 2 → 1.
- Car 2 at 1, level 0 (step 2) → 639; car 4 at 2, level 0 (step 3) → 639.
- i_Freeze high across a tick → positions unchanged; o_Update_Done still pulses once.
- i_V_Counter held at 480 for many lines → a single tick only; i_Level changed from 0 to 7 at E2 → that frame still uses level 0, and the next frame uses step 8/9/8/10.
- i_Reset pulsed at E3 mid-update → outputs immediately return to {0, 160, 320, 480}; no o_Update_Done; the next tick resumes normal stepping.

Source files
------------

// File: rtl/car_traffic_controller_pkg.sv
// Shared constants and types for the car traffic controller: lane geometry,
// per-car base speed, direction and FSM state encoding.
package car_traffic_controller_pkg;

  localparam int unsigned NUM_CARS = 4;
  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned STEP_W   = 4;
  localparam int unsigned LVL_W    = 3;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned CNT_W    = 10;

  // Element [n] belongs to car n+1
  localparam logic [NUM_CARS-1:0][Y_W-1:0]    LANE_Y    = {9'd288, 9'd224, 9'd160, 9'd96};
  localparam logic [NUM_CARS-1:0][STEP_W-1:0] BASE_STEP = {4'd3, 4'd1, 4'd2, 4'd1};
  localparam logic [NUM_CARS-1:0][STEP_W-1:0] INIT_MULT = {4'd15, 4'd10, 4'd5, 4'd0};
  // Bit set means the car moves left (-X)
  localparam logic [NUM_CARS-1:0]             CAR_DIR   = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/car_traffic_controller_lane_step.sv
// Combinational one-car advance: moves X by step in the given direction and
// wraps into 0..H_VISIBLE_AREA-1 using an 11-bit intermediate.
module car_traffic_controller_lane_step
  import car_traffic_controller_pkg::*;
#(
  parameter int unsigned H_VISIBLE_AREA = 640
) (
  input  logic [X_W-1:0]    i_x,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_dir_left,
  output logic [X_W-1:0]    o_x_next_c
);

  localparam int unsigned SUM_W = X_W + 1;

  logic [SUM_W-1:0] x_ext;
  logic [SUM_W-1:0] step_ext;
  logic [SUM_W-1:0] h_ext;
  logic [SUM_W-1:0] sum;

  always_comb begin
    x_ext    = SUM_W'(i_x);
    step_ext = SUM_W'(i_step);
    h_ext    = SUM_W'(H_VISIBLE_AREA);
    sum      = '0;
    if (i_dir_left) begin
      if (x_ext < step_ext) sum = x_ext + h_ext - step_ext;
      else                  sum = x_ext - step_ext;
    end else begin
      sum = x_ext + step_ext;
      if (sum >= h_ext) sum = sum - h_ext;
    end
    o_x_next_c = X_W'(sum);
  end

endmodule

// File: rtl/car_traffic_controller.sv
// Per-frame car position generator: detects the start of vertical blanking,
// steps the four cars serially through one shared lane stepper, then commits.
module car_traffic_controller
  import car_traffic_controller_pkg::*;
#(
  parameter int unsigned TILE_SIZE      = 32,
  parameter int unsigned H_VISIBLE_AREA = 640,
  parameter int unsigned V_VISIBLE_AREA = 480
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [CNT_W-1:0] i_H_Counter,
  input  logic [CNT_W-1:0] i_V_Counter,
  input  logic [LVL_W-1:0] i_Level,
  input  logic             i_Freeze,
  output logic [X_W-1:0]   o_Car_1X_Position,
  output logic [X_W-1:0]   o_Car_2X_Position,
  output logic [X_W-1:0]   o_Car_3X_Position,
  output logic [X_W-1:0]   o_Car_4X_Position,
  output logic [Y_W-1:0]   o_Car_1Y_Position,
  output logic [Y_W-1:0]   o_Car_2Y_Position,
  output logic [Y_W-1:0]   o_Car_3Y_Position,
  output logic [Y_W-1:0]   o_Car_4Y_Position,
  output logic             o_Update_Done
);

  localparam logic [NUM_CARS-1:0][X_W-1:0] INIT_X = {
    X_W'(INIT_MULT[3] * TILE_SIZE), X_W'(INIT_MULT[2] * TILE_SIZE),
    X_W'(INIT_MULT[1] * TILE_SIZE), X_W'(INIT_MULT[0] * TILE_SIZE)
  };

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [LVL_W-1:0]             level_q, level_d;
  logic                         freeze_q, freeze_d;
  logic [CNT_W-1:0]             v_prev_q, v_prev_d;
  logic [NUM_CARS-1:0][X_W-1:0] work_x_q, work_x_d;
  logic [NUM_CARS-1:0][X_W-1:0] out_x_q, out_x_d;
  logic                         done_q, done_d;

  logic                         tick_c;
  logic [STEP_W-1:0]            step_c;
  logic [X_W-1:0]               lane_x_next_c;

  // Horizontal position plays no part in the frame tick
  logic unused_h_counter;
  assign unused_h_counter = ^i_H_Counter;

  assign tick_c = (i_V_Counter == CNT_W'(V_VISIBLE_AREA)) &&
                  (v_prev_q != CNT_W'(V_VISIBLE_AREA));
  assign step_c = freeze_q ? '0 : BASE_STEP[idx_q] + STEP_W'(level_q);

  car_traffic_controller_lane_step #(
    .H_VISIBLE_AREA (H_VISIBLE_AREA)
  ) u_lane_step (
    .i_x        (work_x_q[idx_q]),
    .i_step     (step_c),
    .i_dir_left (CAR_DIR[idx_q]),
    .o_x_next_c (lane_x_next_c)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    level_d  = level_q;
    freeze_d = freeze_q;
    v_prev_d = i_V_Counter;
    work_x_d = work_x_q;
    out_x_d  = out_x_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_c) begin
          state_d  = S_CALC;
          idx_d    = '0;
          level_d  = i_Level;
          freeze_d = i_Freeze;
        end
      end
      S_CALC: begin
        work_x_d[idx_q] = lane_x_next_c;
        idx_d           = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_CARS - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        out_x_d = work_x_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      level_q  <= '0;
      freeze_q <= 1'b0;
      v_prev_q <= '0;
      work_x_q <= INIT_X;
      out_x_q  <= INIT_X;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      level_q  <= level_d;
      freeze_q <= freeze_d;
      v_prev_q <= v_prev_d;
      work_x_q <= work_x_d;
      out_x_q  <= out_x_d;
      done_q   <= done_d;
    end
  end

  assign o_Car_1X_Position = out_x_q[0];
  assign o_Car_2X_Position = out_x_q[1];
  assign o_Car_3X_Position = out_x_q[2];
  assign o_Car_4X_Position = out_x_q[3];
  assign o_Car_1Y_Position = LANE_Y[0];
  assign o_Car_2Y_Position = LANE_Y[1];
  assign o_Car_3Y_Position = LANE_Y[2];
  assign o_Car_4Y_Position = LANE_Y[3];
  assign o_Update_Done     = done_q;

endmodule

// File: tb/tb_car_traffic_controller.sv
// Randomized frame-level bench for car_traffic_controller with a modulo-arithmetic
// position model, plus directed reset, freeze, held-tick and mid-update reset cases.
module tb_car_traffic_controller;

  logic       clk;
  logic       rst;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [2:0] level;
  logic       freeze;
  logic [9:0] x1, x2, x3, x4;
  logic [8:0] y1, y2, y3, y4;
  logic       done;

  int total = 0;
  int bad   = 0;

  int mdl_x[4];
  int init_x[4] = '{0, 160, 320, 480};
  int base[4]   = '{1, 2, 1, 3};
  int lane_y[4] = '{96, 160, 224, 288};
  int dut_x[4];

  car_traffic_controller #(
    .TILE_SIZE      (32),
    .H_VISIBLE_AREA (640),
    .V_VISIBLE_AREA (480)
  ) dut (
    .i_Clk             (clk),
    .i_Reset           (rst),
    .i_H_Counter       (h_cnt),
    .i_V_Counter       (v_cnt),
    .i_Level           (level),
    .i_Freeze          (freeze),
    .o_Car_1X_Position (x1),
    .o_Car_2X_Position (x2),
    .o_Car_3X_Position (x3),
    .o_Car_4X_Position (x4),
    .o_Car_1Y_Position (y1),
    .o_Car_2Y_Position (y2),
    .o_Car_3Y_Position (y3),
    .o_Car_4Y_Position (y4),
    .o_Update_Done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dut_x[0] = int'(x1);
    dut_x[1] = int'(x2);
    dut_x[2] = int'(x3);
    dut_x[3] = int'(x4);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_x(input string tag, input int exp[4]);
    for (int n = 0; n < 4; n++) chk($sformatf("%s_car%0d", tag, n + 1), dut_x[n], exp[n]);
  endtask

  // Cars 1 and 3 move right, 2 and 4 left; everything wraps modulo the visible width
  function automatic void advance(input int lvl, input bit frz, inout int pos[4]);
    for (int n = 0; n < 4; n++) begin
      int s;
      s = frz ? 0 : base[n] + lvl;
      if (n == 0 || n == 2) pos[n] = (pos[n] + s) % 640;
      else                  pos[n] = (pos[n] - s + 640) % 640;
    end
  endfunction

  // One frame: V sits on 480 for 'hold' cycles starting just before tick edge E0
  task automatic run_frame(input int lvl, input bit frz, input int hold,
                           input bit chg_lvl, input bit rst_mid);
    int exp_new[4];
    int extra;
    exp_new = mdl_x;
    advance(lvl, frz, exp_new);
    @(negedge clk);
    v_cnt  = 10'd480;
    level  = 3'(lvl);
    freeze = frz;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rst_mid && k == 2) begin
        rst = 1'b1;
        #1;
        chk_x("rst_mid", init_x);
        chk("rst_mid_done", int'(done), 0);
        v_cnt = 10'd100;
        @(negedge clk);
        rst = 1'b0;
        mdl_x = init_x;
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          chk("post_rst_done", int'(done), 0);
        end
        chk_x("post_rst", init_x);
        return;
      end
      chk($sformatf("done_e%0d", k), int'(done), (k == 5) ? 1 : 0);
      if (k == 4) chk_x("pre_commit", mdl_x);
      if (k == 5) chk_x("post_commit", exp_new);
      if (chg_lvl && k == 2) level = 3'd7;
      if (k >= hold - 1) v_cnt = 10'd100;
    end
    extra = 0;
    for (int j = 8; j < hold; j++) begin
      @(negedge clk);
      if (done) extra++;
    end
    if (hold > 8) chk("held_tick_extra_done", extra, 0);
    v_cnt = 10'd100;
    @(negedge clk);
    mdl_x = exp_new;
  endtask

  initial begin
    rst    = 1'b1;
    h_cnt  = '0;
    v_cnt  = '0;
    level  = '0;
    freeze = 1'b0;
    mdl_x  = init_x;
    repeat (3) @(negedge clk);
    chk_x("reset", init_x);
    chk("reset_done", int'(done), 0);
    chk("y1", int'(y1), lane_y[0]);
    chk("y2", int'(y2), lane_y[1]);
    chk("y3", int'(y3), lane_y[2]);
    chk("y4", int'(y4), lane_y[3]);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_x("idle_after_reset", init_x);

    run_frame(0, 1'b0, 1, 1'b0, 1'b0);
    chk("lvl0_car1", dut_x[0], 1);
    chk("lvl0_car2", dut_x[1], 158);
    chk("lvl0_car3", dut_x[2], 321);
    chk("lvl0_car4", dut_x[3], 477);

    // Long tick line with level raised mid-update: this frame still uses level 0
    run_frame(0, 1'b0, 40, 1'b1, 1'b0);
    run_frame(7, 1'b0, 2, 1'b0, 1'b0);
    chk("lvl7_car1", dut_x[0], 2 + 8);
    chk("lvl7_car4", dut_x[3], 474 - 10);

    run_frame(5, 1'b1, 3, 1'b0, 1'b0);
    run_frame(3, 1'b0, 1, 1'b0, 1'b1);
    run_frame(0, 1'b0, 1, 1'b0, 1'b0);

    for (int f = 0; f < 60; f++) begin
      run_frame(int'($urandom_range(7, 0)), ($urandom_range(4, 0) == 0),
                int'($urandom_range(12, 1)), $urandom_range(1, 0) == 1, 1'b0);
      repeat (int'($urandom_range(4, 0))) @(negedge clk);
    end

    run_frame(2, 1'b0, 1, 1'b0, 1'b1);
    run_frame(6, 1'b0, 20, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
